ws_column_sequencer: RTL

- Initiator side of the weight-stationary PE control/a/d protocol.
- Drives the top of one column of ROWS chained PEs: emits the control code, the d bus (weights during load, zero psum seed during compute) and per-row activations with systolic skew.
- Accepts commands plus weight/activation streams over valid/ready handshakes; reports completion once the last partial sum has left the column.

---
 rtl/ws_column_sequencer_if.sv | 42 ++++
 rtl/ws_column_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ws_column_sequencer_if.sv
// Bundle of command, weight/activation streams and PE-column outputs for the
// weight-stationary column sequencer. master = sequencer side, slave = stimulus side.
interface ws_column_sequencer_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ROWS       = 2,
    parameter int LEN_WIDTH  = 8
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_op;
    logic [LEN_WIDTH-1:0]         cmd_len;

    logic                         w_valid;
    logic                         w_ready;
    logic [WORD_WIDTH-1:0]        w_data;

    logic                         act_valid;
    logic                         act_ready;
    logic [ROWS*WORD_WIDTH-1:0]   act_data;

    logic [1:0]                   control;
    logic [WORD_WIDTH*4-1:0]      d_in;
    logic [ROWS*WORD_WIDTH-1:0]   a_in;
    logic                         busy;
    logic                         done;

    modport master (
        input  cmd_valid, cmd_op, cmd_len,
        input  w_valid, w_data,
        input  act_valid, act_data,
        output cmd_ready, w_ready, act_ready,
        output control, d_in, a_in, busy, done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len,
        output w_valid, w_data,
        output act_valid, act_data,
        input  cmd_ready, w_ready, act_ready,
        input  control, d_in, a_in, busy, done
    );
endinterface

// File: rtl/ws_column_sequencer.sv
// Drives the top of one weight-stationary PE column: weight load beats, compute
// beats with per-row activation skew, and a completion pulse after the column drains.
module ws_column_sequencer #(
    parameter int WORD_WIDTH = 8,
    parameter int ROWS       = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ws_column_sequencer_if.master bus
);
    localparam int CW = $clog2(ROWS + 1);
    localparam int DW = WORD_WIDTH * 4;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    localparam logic [1:0] CTRL_HOLD    = 2'b00;
    localparam logic [1:0] CTRL_LOAD    = 2'b01;
    localparam logic [1:0] CTRL_COMPUTE = 2'b10;

    localparam logic [CW-1:0]        ROWS_C   = CW'(ROWS);
    localparam logic [CW-1:0]        LAST_W   = CW'(ROWS - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    logic [1:0]                 state_q, state_d;
    logic [CW-1:0]              wcnt_q, wcnt_d;
    logic [CW-1:0]              flush_q, flush_d;
    logic [LEN_WIDTH-1:0]       remaining_q, remaining_d;
    logic [1:0]                 control_q, control_d;
    logic [DW-1:0]              d_in_q, d_in_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [ROWS*WORD_WIDTH-1:0] a_in_w;

    logic cmd_fire;
    logic w_fire;
    logic act_fire;

    // Readies depend only on state so no valid->ready combinational path exists.
    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.w_ready   = (state_q == S_LOAD);
    assign bus.act_ready = (state_q == S_COMPUTE);

    assign cmd_fire = bus.cmd_valid & (state_q == S_IDLE);
    assign w_fire   = bus.w_valid   & (state_q == S_LOAD);
    assign act_fire = bus.act_valid & (state_q == S_COMPUTE);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        flush_d     = flush_q;
        remaining_d = remaining_q;
        control_d   = CTRL_HOLD;
        d_in_d      = '0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (!bus.cmd_op) begin
                        state_d = S_LOAD;
                        wcnt_d  = '0;
                    end else if (bus.cmd_len != '0) begin
                        state_d     = S_COMPUTE;
                        remaining_d = bus.cmd_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (w_fire) begin
                    control_d = CTRL_LOAD;
                    d_in_d    = DW'(bus.w_data);
                    if (wcnt_q != ROWS_C) begin
                        wcnt_d = wcnt_q + CNT_ONE;
                    end
                    // done rides with the final load beat itself.
                    if (wcnt_q == LAST_W) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_COMPUTE: begin
                if (act_fire) begin
                    control_d   = CTRL_COMPUTE;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                    end
                end
            end

            S_FLUSH: begin
                // ROWS+1 state cycles: ROWS visible hold beats after the last compute beat.
                if (flush_q == ROWS_C) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    flush_d = flush_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            flush_q     <= '0;
            remaining_q <= '0;
            control_q   <= CTRL_HOLD;
            d_in_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            flush_q     <= flush_d;
            remaining_q <= remaining_d;
            control_q   <= control_d;
            d_in_q      <= d_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Row r gets a line of r+1 registers; non-accept cycles push a zero slot so
    // bubbles travel down the column aligned with the activations.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [WORD_WIDTH-1:0] line_q [gi+1];
        logic [WORD_WIDTH-1:0] line_d [gi+1];

        always_comb begin
            line_d[0] = act_fire ? bus.act_data[gi*WORD_WIDTH +: WORD_WIDTH] : '0;
            for (int k = 1; k <= gi; k++) begin
                line_d[k] = line_q[k-1];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k <= gi; k++) begin
                    line_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k <= gi; k++) begin
                    line_q[k] <= line_d[k];
                end
            end
        end

        assign a_in_w[gi*WORD_WIDTH +: WORD_WIDTH] = line_q[gi];
    end

    assign bus.control = control_q;
    assign bus.d_in    = d_in_q;
    assign bus.a_in    = a_in_w;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
